// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return address stack: address width, parameter defaults, FSM encoding.
package mips_pkg;
    localparam int                ADDR_W       = 32;
    localparam int                RAS_DEPTH    = 8;
    localparam logic [ADDR_W-1:0] RAS_LINK_INC = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } ras_state_e;
endpackage

// File: rtl/return_addr_stack_if.sv
// Push/pop request and status bundle of the return address stack.
// Macro RETURN_ADDR_STACK_STATS_EN adds the push_cnt/pop_cnt statistics outputs.
interface return_addr_stack_if;
    logic                        en;
    logic                        push;
    logic                        pop;
    logic [mips_pkg::ADDR_W-1:0] pc;
    logic [mips_pkg::ADDR_W-1:0] ret_addr;
    logic                        pop_done;
    logic                        empty;
    logic                        full;
    logic                        overflow;
    logic                        underflow;
`ifdef RETURN_ADDR_STACK_STATS_EN
    logic [15:0]                 push_cnt;
    logic [15:0]                 pop_cnt;

    modport master (output en, push, pop, pc,
                    input  ret_addr, pop_done, empty, full, overflow, underflow, push_cnt, pop_cnt);
    modport slave  (input  en, push, pop, pc,
                    output ret_addr, pop_done, empty, full, overflow, underflow, push_cnt, pop_cnt);
`else
    modport master (output en, push, pop, pc,
                    input  ret_addr, pop_done, empty, full, overflow, underflow);
    modport slave  (input  en, push, pop, pc,
                    output ret_addr, pop_done, empty, full, overflow, underflow);
`endif
endinterface

// File: rtl/return_addr_stack_mem.sv
// Stack storage: one synchronous write port, one combinational read port, no reset.
module ras_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);
    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/return_addr_stack.sv
// Circular return address stack: push link on jal/jalr, pop on jr $ra, one-cycle pop latency.
// Macro RETURN_ADDR_STACK_STATS_EN adds 16-bit push/pop counters.
module return_addr_stack
    import mips_pkg::*;
#(
    parameter int                DEPTH    = RAS_DEPTH,
    parameter logic [ADDR_W-1:0] LINK_INC = RAS_LINK_INC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    return_addr_stack_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  top;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] link, rd_data, ret_q;
    logic [PTR_W-1:0]  waddr;
    logic              do_push, do_pop, is_empty, is_full, we;
    logic              pop_done_q, overflow_q, underflow_q;
    ras_state_e        state;

    assign do_push  = bus.en & bus.push;
    assign do_pop   = bus.en & bus.pop;
    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(DEPTH));
    assign link     = bus.pc + LINK_INC;

    // A simultaneous push/pop replaces the top entry in place; on an empty
    // stack the link is forwarded straight to ret_addr and nothing is stored.
    assign we    = do_push & ~(do_pop & is_empty);
    assign waddr = do_pop ? top : top + PTR_W'(1);

    ras_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (link),
        .raddr (top),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pop_done_q <= 1'b0;
        end else if (!bus.en) begin
            state      <= IDLE;
            pop_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= do_pop ? DONE : IDLE;
                    pop_done_q <= do_pop;
                end
                DONE: begin
                    state      <= do_pop ? DONE : IDLE;
                    pop_done_q <= do_pop;
                end
                default: begin
                    state      <= IDLE;
                    pop_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top         <= '0;
            count       <= '0;
            ret_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= do_pop & ~do_push & is_empty;
            case ({do_push, do_pop})
                2'b10: begin
                    top <= top + PTR_W'(1);
                    if (is_full) overflow_q <= 1'b1;
                    else         count      <= count + CNT_W'(1);
                end
                2'b01: begin
                    if (is_empty) begin
                        ret_q <= '0;
                    end else begin
                        ret_q <= rd_data;
                        top   <= top - PTR_W'(1);
                        count <= count - CNT_W'(1);
                    end
                end
                2'b11:   ret_q <= is_empty ? link : rd_data;
                default: ;
            endcase
        end
    end

`ifdef RETURN_ADDR_STACK_STATS_EN
    logic [15:0] push_cnt_q, pop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            if (do_push) push_cnt_q <= push_cnt_q + 16'd1;
            if (do_pop)  pop_cnt_q  <= pop_cnt_q + 16'd1;
        end
    end

    assign bus.push_cnt = push_cnt_q;
    assign bus.pop_cnt  = pop_cnt_q;
`endif

    assign bus.ret_addr  = ret_q;
    assign bus.pop_done  = pop_done_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
- REQ-001 SHALL have parameter DEPTH, default 8: number of stack entries; power of two, 2..32.
- REQ-002 SHALL have parameter LINK_INC, default 32'd4: increment added to pc to form the link address.
- REQ-003 clk  input  1  system clock; all state changes on the rising edge.
- REQ-004 rst_n  input  1  reset, asynchronous and active-low.
- REQ-005 en  input  1  block enable; push and pop are ignored while low.
- REQ-006 push  input  1  jal/jalr retired; push the link address.
- REQ-007 pop  input  1  jr $ra retired; request the return address.
- REQ-008 pc  input  32  PC of the instruction issuing push.
- REQ-009 ret_addr  output  32  popped return address; holds its value between pops.
- REQ-010 pop_done  output  1  one-cycle pulse: ret_addr is valid.
- REQ-011 empty  output  1  count == 0.
- REQ-012 full  output  1  count == DEPTH.
- REQ-013 overflow  output  1  sticky: a push occurred while full.
- REQ-014 underflow  output  1  one-cycle pulse: a pop occurred while empty.

Function
- REQ-015 Link value SHALL be pc + LINK_INC, computed modulo 2^32.
- REQ-016 The stack SHALL be circular, with pointer top and count 0..DEPTH; pointer arithmetic SHALL wrap modulo DEPTH.
- REQ-017 Push with en=1 and pop=0 SHALL write the link to entry top+1, advance top, and increment count, saturating at DEPTH.
- REQ-018 Push while full SHALL overwrite the oldest entry, keep count at DEPTH, and set overflow.
- REQ-019 Pop with en=1 and push=0 on a non-empty stack SHALL register ret_addr = mem[top], decrement top, and decrement count.
- REQ-020 Pop while empty SHALL register ret_addr = 0, pulse underflow, and leave pointers unchanged.
- REQ-021 Push and pop in the same cycle SHALL register ret_addr = mem[top], then overwrite mem[top] with the link; count is unchanged.
- REQ-022 When push and pop coincide on an empty stack, the link SHALL be returned as ret_addr and count SHALL remain 0.
- REQ-023 The control FSM SHALL have two states, IDLE and DONE.
- REQ-024 IDLE SHALL move to DONE when pop is sampled with en=1.
- REQ-025 DONE SHALL assert pop_done for exactly one cycle.
- REQ-026 From DONE, the FSM SHALL return to IDLE, or stay in DONE if pop is sampled again.
- REQ-027 Pop latency SHALL be one cycle: pop sampled at edge N gives pop_done=1 and valid ret_addr after edge N+1.
- REQ-028 en=0 SHALL freeze pointers, count and ret_addr, and SHALL force the FSM to IDLE.

Reset
- REQ-029 rst_n=0 SHALL immediately clear ret_addr, pop_done, overflow, underflow, top and count, and set the FSM to IDLE.
- REQ-030 empty SHALL read 1 and full SHALL read 0 during reset and after reset.
- REQ-031 Stack memory contents SHALL need no reset.
- REQ-032 Reset mid-pop SHALL suppress the pending pop_done.

Configuration
- REQ-033 With macro RETURN_ADDR_STACK_STATS_EN defined, the block SHALL add two 16-bit outputs, push_cnt and pop_cnt.
- REQ-034 push_cnt and pop_cnt SHALL count accepted pushes and pops, wrap at 2^16, and clear on reset.
- REQ-035 With RETURN_ADDR_STACK_STATS_EN undefined, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
- REQ-036 The shared package mips_pkg SHALL hold ADDR_W=32, the DEPTH and LINK_INC defaults, and the FSM state encoding.
- REQ-037 Storage SHALL be a sub-module ras_mem: DEPTH x 32, one synchronous write port and one combinational read port.

Verification
- REQ-038 Reset then pc=3, push, en=1 -> one cycle later count=1 and empty=0; next pop -> ret_addr=7, pop_done pulses one cycle, then empty=1.
- REQ-039 Push pc=0,4,...,28 (8 pushes) -> full=1; push pc=100 -> overflow=1; 8 pops -> 104, 32, 28, 24, 20, 16, 12, 8.
- REQ-040 Pop on empty -> ret_addr=0, underflow pulses, pop_done pulses, count stays 0.
- REQ-041 Stack holds 8; push pc=50 and pop together -> ret_addr=8, count unchanged; next pop -> 54.
- REQ-042 en=0 while push=1 and pop=1 for 5 cycles -> no state change, pop_done=0; assert rst_n=0 in the cycle after a pop -> pop_done never asserts, count=0.
